// File: rtl/burst_pmem.sv
// Line-oriented burst memory: one request moves a whole line as BEATS beats after a fixed latency.
// Optional BURST_PMEM_STATS_EN macro adds saturating completed-read/write line counters.
module burst_pmem #(
  parameter int DATA_W      = 64,
  parameter int BEATS       = 4,
  parameter int DEPTH_LINES = 256,
  parameter int LATENCY     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       mem_address,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_resp,
  output logic              proto_err
`ifdef BURST_PMEM_STATS_EN
  ,
  output logic [15:0]       rd_lines,
  output logic [15:0]       wr_lines
`endif
);

  localparam int LINE_W = $clog2(DEPTH_LINES);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [3:0] LAT_INIT = 4'(LATENCY - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [2:0] {IDLE, WAIT, RBURST, WBURST, DONE} state_e;

  state_e              state_q, state_d;
  logic [3:0]          lat_q, lat_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic                dir_wr_q, dir_wr_d;
  logic                illegal;
  logic                done_entry;

  logic                resp_q;
  logic [BEAT_W-1:0]   resp_beat_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                perr_q;

  logic [DATA_W-1:0]   mem_q [DEPTH_LINES][BEATS];

  logic unused_addr;
  assign unused_addr = ^{mem_address[31:5+LINE_W], mem_address[4:0]};

  always_comb begin
    state_d    = state_q;
    lat_d      = lat_q;
    beat_d     = beat_q;
    line_d     = line_q;
    dir_wr_d   = dir_wr_q;
    illegal    = 1'b0;
    done_entry = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_read ^ mem_write) begin
          line_d   = mem_address[4+LINE_W:5];
          dir_wr_d = mem_write;
          lat_d    = LAT_INIT;
          state_d  = WAIT;
        end else if (mem_read && mem_write) begin
          illegal = 1'b1;
        end
      end
      WAIT: begin
        if (lat_q == 4'd0) begin
          beat_d  = '0;
          state_d = dir_wr_q ? WBURST : RBURST;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      RBURST, WBURST: begin
        if (beat_q == LAST_BEAT) begin
          state_d    = DONE;
          done_entry = 1'b1;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage boundary: FSM state plus registered outputs, which trail the burst state by one cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      lat_q       <= '0;
      beat_q      <= '0;
      line_q      <= '0;
      dir_wr_q    <= 1'b0;
      resp_q      <= 1'b0;
      resp_beat_q <= '0;
      rdata_q     <= '0;
      perr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      beat_q      <= beat_d;
      line_q      <= line_d;
      dir_wr_q    <= dir_wr_d;
      resp_q      <= (state_q == RBURST) || (state_q == WBURST);
      resp_beat_q <= beat_q;
      rdata_q     <= (state_q == RBURST) ? mem_q[line_q][beat_q] : '0;
      perr_q      <= illegal;
    end
  end

  // Write beats land at the edge closing their response cycle; reset kills resp_q so aborted beats never land
  always_ff @(posedge clk) begin
    if (resp_q && dir_wr_q) begin
      mem_q[line_q][resp_beat_q] <= mem_wdata;
    end
  end

  assign mem_resp  = resp_q;
  assign mem_rdata = rdata_q;
  assign proto_err = perr_q;

`ifdef BURST_PMEM_STATS_EN
  logic [15:0] rd_lines_q, wr_lines_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_lines_q <= '0;
      wr_lines_q <= '0;
    end else if (done_entry) begin
      if (!dir_wr_q && (rd_lines_q != 16'hFFFF)) rd_lines_q <= rd_lines_q + 16'd1;
      if (dir_wr_q && (wr_lines_q != 16'hFFFF)) wr_lines_q <= wr_lines_q + 16'd1;
    end
  end

  assign rd_lines = rd_lines_q;
  assign wr_lines = wr_lines_q;
`else
  logic unused_done;
  assign unused_done = done_entry;
`endif

endmodule

// File: tb/tb_burst_pmem.sv
// Scoreboard bench for burst_pmem: three latency variants share stimulus, the LATENCY=3 one is fully checked.
module tb_burst_pmem;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_address;
  logic        mem_read, mem_write;
  logic [63:0] mem_wdata;
  logic [63:0] rdata0, rdata1, rdata15;
  logic        resp0, resp1, resp15;
  logic        perr0, perr1, perr15;
`ifdef BURST_PMEM_STATS_EN
  logic [15:0] rdl0, wrl0, rdl1, wrl1, rdl15, wrl15;
`endif

  always #5 clk = ~clk;

  burst_pmem #(.DATA_W(64), .BEATS(4), .DEPTH_LINES(256), .LATENCY(3)) dut (
    .clk(clk), .rst(rst), .mem_address(mem_address), .mem_read(mem_read),
    .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_rdata(rdata0),
    .mem_resp(resp0), .proto_err(perr0)
`ifdef BURST_PMEM_STATS_EN
    , .rd_lines(rdl0), .wr_lines(wrl0)
`endif
  );

  burst_pmem #(.DATA_W(64), .BEATS(4), .DEPTH_LINES(256), .LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst), .mem_address(mem_address), .mem_read(mem_read),
    .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_rdata(rdata1),
    .mem_resp(resp1), .proto_err(perr1)
`ifdef BURST_PMEM_STATS_EN
    , .rd_lines(rdl1), .wr_lines(wrl1)
`endif
  );

  burst_pmem #(.DATA_W(64), .BEATS(4), .DEPTH_LINES(256), .LATENCY(15)) dut_l15 (
    .clk(clk), .rst(rst), .mem_address(mem_address), .mem_read(mem_read),
    .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_rdata(rdata15),
    .mem_resp(resp15), .proto_err(perr15)
`ifdef BURST_PMEM_STATS_EN
    , .rd_lines(rdl15), .wr_lines(wrl15)
`endif
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_rd = 0;
  int          n_wr = 0;
  logic [63:0] model [256][4];
  logic [63:0] exp_q [$];
  logic [63:0] wb [4];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic set_wb(input logic [63:0] b0, input logic [63:0] b1,
                        input logic [63:0] b2, input logic [63:0] b3);
    wb[0] = b0; wb[1] = b1; wb[2] = b2; wb[3] = b3;
  endtask

  // One transaction, observed for 30 cycles after the accept edge (c = edges since accept).
  task automatic run_txn(input bit wr, input logic [31:0] addr, input bit noise, input bit abort);
    int idx, first0, last0, first1, first15, nresp, zero_bad;
    idx = int'((addr >> 5) % 256);
    if (!wr) for (int j = 0; j < 4; j++) exp_q.push_back(model[idx][j]);
    first0 = -1; last0 = -1; first1 = -1; first15 = -1; nresp = 0; zero_bad = 0;
    mem_address = addr;
    mem_read    = !wr;
    mem_write   = wr;
    @(posedge clk); #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (resp1 && first1 < 0) first1 = c;
      if (resp15 && first15 < 0) first15 = c;
      if (resp0) begin
        if (first0 < 0) first0 = c;
        last0 = c;
        if (wr) begin
          if (abort && nresp == 1) begin
            rst = 1'b0;
            #1;
            check("abort_resp", {63'd0, resp0}, 64'd0);
            check("abort_rdata", rdata0, 64'd0);
            repeat (2) @(negedge clk);
            rst  = 1'b1;
            n_rd = 0;
            n_wr = 0;
            return;
          end
          mem_wdata = wb[nresp];
          model[idx][nresp] = wb[nresp];
        end else if (exp_q.size() == 0) begin
          check("sb_underflow", 64'd1, 64'd0);
        end else begin
          check($sformatf("rd_beat%0d", nresp), rdata0, exp_q.pop_front());
        end
        nresp++;
      end else if (rdata0 !== 64'd0) begin
        zero_bad++;
      end
      if (noise && c == 5) begin mem_write = 1'b1; mem_address = 32'h40; end
      if (noise && c == 6) mem_write = 1'b0;
    end
    check("first_resp_lat3", 64'(first0), 64'd4);
    check("resp_run", 64'(last0 - first0), 64'd3);
    check("resp_count", 64'(nresp), 64'd4);
    check("rdata_zero_when_idle", 64'(zero_bad), 64'd0);
    check("first_resp_lat1", 64'(first1), 64'd2);
    check("first_resp_lat15", 64'(first15), 64'd16);
    check("sb_leftover", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    if (nresp == 4) begin
      if (wr) n_wr++;
      else n_rd++;
    end
  endtask

  initial begin
    int bad;
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_address = '0; mem_wdata = '0;
    #2 rst = 1'b0;
    #1;
    check("rst_resp", {63'd0, resp0}, 64'd0);
    check("rst_rdata", rdata0, 64'd0);
    check("rst_perr", {63'd0, perr0}, 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    set_wb(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
           64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444);
    run_txn(1'b1, 32'h0000_0040, 1'b0, 1'b0);
    run_txn(1'b0, 32'h0000_0040, 1'b0, 1'b0);
    run_txn(1'b0, 32'h0000_2040, 1'b0, 1'b0);

    set_wb(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
           64'hDEAD_BEEF_0000_0001, 64'h8000_0000_0000_0000);
    run_txn(1'b1, 32'h0000_0060, 1'b0, 1'b0);
    set_wb(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h5A5A_5A5A_5A5A_5A5A, 64'hA5A5_A5A5_A5A5_A5A5);
    run_txn(1'b1, 32'hFFFF_FFE0, 1'b0, 1'b0);
    run_txn(1'b0, 32'h0000_1FE0, 1'b0, 1'b0);

    mem_address = 32'h40; mem_read = 1'b1; mem_write = 1'b1;
    @(posedge clk); #1;
    check("proto_err_pulse", {63'd0, perr0}, 64'd1);
    mem_read = 1'b0; mem_write = 1'b0;
    @(posedge clk); #1;
    check("proto_err_clear", {63'd0, perr0}, 64'd0);
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (resp0) bad++;
    end
    check("proto_no_resp", 64'(bad), 64'd0);

    run_txn(1'b0, 32'h0000_0060, 1'b1, 1'b0);

`ifdef BURST_PMEM_STATS_EN
    check("stats_rd", {48'd0, rdl0}, 64'(n_rd));
    check("stats_wr", {48'd0, wrl0}, 64'(n_wr));
`endif

    set_wb(64'hA0A0_A0A0_A0A0_A0A0, 64'hA1A1_A1A1_A1A1_A1A1,
           64'hA2A2_A2A2_A2A2_A2A2, 64'hA3A3_A3A3_A3A3_A3A3);
    run_txn(1'b1, 32'h0000_0040, 1'b0, 1'b1);
`ifdef BURST_PMEM_STATS_EN
    check("stats_rd_rst", {48'd0, rdl0}, 64'd0);
    check("stats_wr_rst", {48'd0, wrl0}, 64'd0);
`endif
    run_txn(1'b0, 32'h0000_0040, 1'b0, 1'b0);
`ifdef BURST_PMEM_STATS_EN
    check("stats_rd_after", {48'd0, rdl0}, 64'(n_rd));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/burst_pmem.md
BURST_PMEM -- requirements
Module: burst_pmem

Interface
REQ-001 SHALL have parameter DATA_W, default 64, giving the width of one burst beat in bits.
REQ-002 SHALL have parameter BEATS, default 4, giving the beats per cache line (line = 256 bits).
REQ-003 SHALL have parameter DEPTH_LINES, default 256, giving the number of lines stored (power of 2).
REQ-004 SHALL have parameter LATENCY, default 3, giving the cycles from request accept to first beat (legal range 1..15).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port mem_address, input, 32 bits: byte address of the line; bits [4:0] ignored.
REQ-008 SHALL have port mem_read, input, 1 bit: line read request.
REQ-009 SHALL have port mem_write, input, 1 bit: line write request.
REQ-010 SHALL have port mem_wdata, input, DATA_W bits: current write beat.
REQ-011 SHALL have port mem_rdata, output, DATA_W bits: current read beat.
REQ-012 SHALL have port mem_resp, output, 1 bit: beat valid (read) / beat consumed (write).
REQ-013 SHALL have port proto_err, output, 1 bit: one-cycle pulse on an illegal request.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RBURST, WBURST, DONE.
REQ-015 In IDLE, SHALL accept on a rising edge where exactly one of mem_read/mem_write is 1; latch the line index = mem_address[4+log2(DEPTH_LINES):5] and the direction; load the latency counter with LATENCY-1; go to WAIT.
REQ-016 Line index SHALL wrap modulo DEPTH_LINES; upper address bits are ignored, with no error.
REQ-017 In IDLE with mem_read=1 and mem_write=1, SHALL stay in IDLE and pulse proto_err high for one cycle.
REQ-018 WAIT SHALL decrement the counter each cycle and, at 0, go to RBURST or WBURST with beat counter = 0.
REQ-019 First mem_resp SHALL be high exactly LATENCY+1 cycles after the accept edge.
REQ-020 RBURST SHALL hold mem_resp=1 for BEATS consecutive cycles, with mem_rdata = beat k (bits [k*DATA_W +: DATA_W] of the line) in the k-th cycle.
REQ-021 WBURST SHALL hold mem_resp=1 for BEATS consecutive cycles and write mem_wdata into beat k of the latched line at the edge ending the k-th cycle.
REQ-022 The host SHALL present write beat k during the k-th mem_resp cycle.
REQ-023 After the last beat, SHALL enter DONE for one cycle with mem_resp=0, then go to IDLE.
REQ-024 A request still asserted in IDLE SHALL start a new transaction; a back-to-back same-line read SHALL return the newly written data.
REQ-025 Request inputs SHALL be ignored outside IDLE; deassertion mid-burst SHALL NOT abort the burst.
REQ-026 mem_rdata SHALL be 0 whenever mem_resp=0.
REQ-027 Storage SHALL be a registered array of DEPTH_LINES x BEATS x DATA_W.

Reset
REQ-028 While rst=0, SHALL hold the FSM in IDLE and clear the counters, mem_resp, mem_rdata and proto_err asynchronously.
REQ-029 Reset asserted mid-burst SHALL abort the burst: beats already written stay written, and later beats are not written.
REQ-030 Reset SHALL NOT clear the storage array.
REQ-031 The first accept SHALL be possible on the first rising edge after rst returns to 1.

Configuration
REQ-032 With BURST_PMEM_STATS_EN defined, SHALL add output ports rd_lines (16 bits) and wr_lines (16 bits).
REQ-033 With BURST_PMEM_STATS_EN defined, rd_lines and wr_lines SHALL increment on each completed read/write burst (at entry to DONE), saturate at 16'hFFFF, and clear on reset.
REQ-034 Without BURST_PMEM_STATS_EN, the ports and counters SHALL be absent, with identical other behaviour.

Verification
REQ-035 Scenario: write line at 0x0000_0040 with beats 0x11..11, 0x22..22, 0x33..33, 0x44..44, then read 0x0000_0040 -> first resp 4 cycles after accept, 4 resp cycles returning the same beats in order, then a DONE gap.
REQ-036 Scenario: read of 0x0000_2040 with DEPTH_LINES=256 -> returns the line at index 2 (wrap).
REQ-037 Scenario: mem_read=mem_write=1 in IDLE -> proto_err high for one cycle, no mem_resp, state stays IDLE.
REQ-038 Scenario: rst driven low during the 2nd write beat -> mem_resp drops immediately; a later read shows beat 0 new and beats 1..3 old.
REQ-039 Scenario: LATENCY=1 and LATENCY=15 -> first resp exactly 2 and 16 cycles after accept.
REQ-040 Scenario: with BURST_PMEM_STATS_EN, 3 reads and 2 writes -> rd_lines=3, wr_lines=2; after reset both are 0.
